multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Multi-cycle MIPS control FSM. Sequences the shared ALU, register file, single-port memory and PC
//  over several cycles per instruction. Replaces the per-instruction combinational decode with a state machine.
//  Memory accesses use a ready handshake with a timeout. Sits between the IR/opcode fields and the datapath mux/enable controls.
// PARAMETERS
//  MEM_TIMEOUT  15  max consecutive wait cycles on MemReady before fault (1..2^WAIT_W-1)
//  WAIT_W       4   width of the memory wait counter
// PORTS
//  Clk       in   1  clock, rising edge
//  Rst       in   1  asynchronous reset, active-low
//  Opcode    in   6  Instruction[31:26] from the IR
//  Funct     in   6  Instruction[5:0] from the IR
//  Zero      in   1  ALU zero flag
//  MemReady  in   1  memory done/accept for the current access
//  IorD      out  1  memory address select: 0=PC, 1=ALUOut
//  MemRead   out  1  memory read request
//  MemWrite  out  1  memory write request
//  IRWrite   out  1  load IR
//  RegDst    out  1  write-register select: 0=rt, 1=rd
//  MemtoReg  out  1  write-data select: 0=ALUOut, 1=MDR
//  RegWrite  out  1  register file write enable
//  ALUSrcA   out  1  ALU A select: 0=PC, 1=rs
//  ALUSrcB   out  2  ALU B select: 00=rt, 01=4, 10=signext, 11=signext<<2
//  ALUOp     out  6  funct-style ALU code: ADD=6'b100000, SUB=6'b100010, else Funct
//  PCSrc     out  2  PC source select: 00=ALU, 01=ALUOut, 10=jump target
//  PCWrite   out  1  PC load enable
//  Fault     out  1  sticky: illegal opcode or memory timeout
//  State     out  4  current state, debug only
// BEHAVIOUR
//  - Moore outputs decoded from the registered state. Unlisted outputs are 0 in each state.
//  - Rst low: state=IDLE, wait counter=0, all outputs 0, including Fault.
//  - IDLE(0): always goes to FETCH.
//  - FETCH(1): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD.
//      IRWrite=PCWrite=MemReady. Goes to DECODE on MemReady; stays otherwise.
//  - DECODE(2): ALUSrcA=0, ALUSrcB=11, ALUOp=ADD.
//      Next state by Opcode: 100011/101011 -> MEM_ADDR, 000000 -> EXEC, 000100 -> BRANCH, any other -> HALT.
//  - MEM_ADDR(3): ALUSrcA=1, ALUSrcB=10, ALUOp=ADD. Goes to MEM_RD for lw, MEM_WR for sw.
//  - MEM_RD(4): IorD=1, MemRead=1. Goes to MEM_WB on MemReady.
//  - MEM_WB(5): RegWrite=1, MemtoReg=1, RegDst=0. Goes to FETCH.
//  - MEM_WR(6): IorD=1, MemWrite=1. Goes to FETCH on MemReady.
//  - EXEC(7): ALUSrcA=1, ALUSrcB=00, ALUOp=Funct. Goes to R_WB.
//  - R_WB(8): RegWrite=1, RegDst=1, MemtoReg=0, ALUOp=Funct. Goes to FETCH.
//  - BRANCH(9): ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCSrc=01, PCWrite=Zero. Goes to FETCH.
//  - HALT(15): Fault=1, all other outputs 0. Terminal until Rst.
//  - Latency in cycles, with zero memory wait: lw 5, sw 4, R-type 4, beq 3. Each wait cycle adds 1.
//  - Wait counter: cleared on entry to FETCH, MEM_RD or MEM_WR.
//      Increments each cycle in those states while MemReady=0.
//      If the count equals MEM_TIMEOUT with MemReady=0, the FSM goes to HALT.
//      If MemReady=1 in that same cycle, MemReady wins and the FSM proceeds normally.
//  - Requests (MemRead/MemWrite) stay held, not pulsed, until MemReady is seen.
//  - Rst asserted mid-access: immediate return to IDLE; the access is dropped with no completion.
// CONFIGURATION
//  - MC_CTRL_JUMP_EN defined: Opcode 000010 in DECODE -> JUMP(10).
//      JUMP drives PCSrc=10, PCWrite=1, then goes to FETCH. j takes 3 cycles.
//  - MC_CTRL_JUMP_EN undefined: Opcode 000010 is illegal -> HALT with Fault=1. State code 10 is unused.
// STRUCTURE
//  - ctrl_pkg holds the shared constants:
//      state encodings (4-bit)
//      opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J)
//      ALUOp codes (ALU_ADD, ALU_SUB)
//      ALUSrcB and PCSrc select codes
//  - One sub-module: mem_wait_timer (clear, tick, ready -> timeout), parameterised on MEM_TIMEOUT and WAIT_W.
// TESTING
//  - Reset then lw, Opcode=100011, MemReady=1 always:
//      IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB.
//      RegWrite=1 and MemtoReg=1 only in cycle 6; PCWrite=1 only in FETCH.
//  - sw with MemReady held 0 for 3 cycles in MEM_WR:
//      MemWrite=1 and IorD=1 held for 4 cycles, then FETCH.
//  - R-type, Funct=100010:
//      ALUOp=100010 in EXEC and R_WB; RegDst=1 and RegWrite=1 in R_WB.
//  - beq with Zero=1, then with Zero=0:
//      PCWrite=1 / 0 in BRANCH, PCSrc=01; returns to FETCH.
//  - MemReady=0 in FETCH for 15 cycles: HALT, Fault=1.
//      Same case but MemReady=1 on cycle 15: DECODE, Fault=0.
//  - Opcode=000010: with MC_CTRL_JUMP_EN, JUMP with PCSrc=10, PCWrite=1; without it, HALT with Fault=1.
//      Separately, Rst pulsed low mid MEM_RD: all outputs 0, State=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: state codes, opcodes,
// ALU function codes and datapath select codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC     = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_HALT     = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] ALU_ADD = 6'b100000;
  localparam logic [5:0] ALU_SUB = 6'b100010;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // States that hold a memory request open until MemReady
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory access and flags the cycle
// in which the MEM_TIMEOUT-th wait happens with MemReady still low.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int WAIT_W      = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  input  logic ready,
  output logic timeout
);

  localparam logic [WAIT_W-1:0] LAST = WAIT_W'(MEM_TIMEOUT - 1);

  logic [WAIT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (tick && !ready)
      count <= count + 1'b1;
  end

  // A ready in the limit cycle still completes the access
  assign timeout = tick && !ready && (count == LAST);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS control FSM driving the shared datapath's selects and enables.
// Define MC_CTRL_JUMP_EN to decode j (opcode 000010) through a JUMP state.
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int WAIT_W      = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [5:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       PCWrite,
  output logic       Fault,
  output logic [3:0] State
);

  state_t state, next_state;
  logic   mem_timeout;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .WAIT_W     (WAIT_W)
  ) u_wait_timer (
    .clk    (Clk),
    .rst_n  (Rst),
    .clear  (next_state != state),
    .tick   (is_wait_state(state)),
    .ready  (MemReady),
    .timeout(mem_timeout)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)
      state <= S_IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:     next_state = S_FETCH;
      S_FETCH:    if (MemReady) next_state = S_DECODE;
                  else if (mem_timeout) next_state = S_HALT;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: next_state = S_MEM_ADDR;
          OP_RTYPE:     next_state = S_EXEC;
          OP_BEQ:       next_state = S_BRANCH;
`ifdef MC_CTRL_JUMP_EN
          OP_J:         next_state = S_JUMP;
`endif
          default:      next_state = S_HALT;
        endcase
      end
      S_MEM_ADDR: begin
        if (Opcode == OP_LW)      next_state = S_MEM_RD;
        else if (Opcode == OP_SW) next_state = S_MEM_WR;
        else                      next_state = S_HALT;
      end
      S_MEM_RD:   if (MemReady) next_state = S_MEM_WB;
                  else if (mem_timeout) next_state = S_HALT;
      S_MEM_WB:   next_state = S_FETCH;
      S_MEM_WR:   if (MemReady) next_state = S_FETCH;
                  else if (mem_timeout) next_state = S_HALT;
      S_EXEC:     next_state = S_R_WB;
      S_R_WB:     next_state = S_FETCH;
      S_BRANCH:   next_state = S_FETCH;
`ifdef MC_CTRL_JUMP_EN
      S_JUMP:     next_state = S_FETCH;
`endif
      S_HALT:     next_state = S_HALT;
      default:    next_state = S_HALT;
    endcase
  end

  // Every control defaults to 0; each state raises only what it uses
  always_comb begin
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_RT;
    ALUOp    = 6'b000000;
    PCSrc    = PC_ALU;
    PCWrite  = 1'b0;
    Fault    = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        ALUOp   = ALU_ADD;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM_SH2;
        ALUOp   = ALU_ADD;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALU_ADD;
      end
      S_MEM_RD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEM_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = Funct;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        ALUOp    = Funct;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_SUB;
        PCSrc   = PC_ALUOUT;
        PCWrite = Zero;
      end
`ifdef MC_CTRL_JUMP_EN
      S_JUMP: begin
        PCSrc   = PC_JUMP;
        PCWrite = 1'b1;
      end
`endif
      S_HALT:  Fault = 1'b1;
      default: ;
    endcase
  end

  assign State = state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed self-checking bench for multicycle_ctrl_fsm; expectations are hand-derived
// per state and follow MC_CTRL_JUMP_EN when it is defined.
module tb_multicycle_ctrl_fsm;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_J     = 6'b000010;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [5:0] Opcode, Funct;
  logic       Zero, MemReady;
  logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [5:0] ALUOp;
  logic       PCWrite, Fault;
  logic [3:0] State;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(15), .WAIT_W(4)) dut (
    .Clk(Clk), .Rst(Rst), .Opcode(Opcode), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSrc(PCSrc), .PCWrite(PCWrite), .Fault(Fault), .State(State)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] allOut();
    return 32'({IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                ALUSrcB, ALUOp, PCSrc, PCWrite, Fault});
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic rdy, input logic z);
    Opcode   = op;
    Funct    = fn;
    MemReady = rdy;
    Zero     = z;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst = 1'b0;
    applyStimulus(OPC_RTYPE, 6'b0, 1'b0, 1'b0);
    nextCycle();
    nextCycle();
    checkOutput("reset_state", 32'(State), 32'd0);
    checkOutput("reset_outs", allOut(), 32'd0);

    // lw with memory always ready
    Rst = 1'b1;
    applyStimulus(OPC_LW, 6'b0, 1'b1, 1'b0);
    checkOutput("lw_c1_idle", 32'(State), 32'd0);
    nextCycle();
    checkOutput("lw_c2_fetch", 32'(State), 32'd1);
    checkOutput("lw_fetch_memread", 32'(MemRead), 32'd1);
    checkOutput("lw_fetch_pcwrite", 32'(PCWrite), 32'd1);
    checkOutput("lw_fetch_irwrite", 32'(IRWrite), 32'd1);
    checkOutput("lw_fetch_srcb", 32'(ALUSrcB), 32'd1);
    checkOutput("lw_fetch_aluop", 32'(ALUOp), 32'h20);
    checkOutput("lw_fetch_regwrite", 32'(RegWrite), 32'd0);
    nextCycle();
    checkOutput("lw_c3_decode", 32'(State), 32'd2);
    checkOutput("lw_decode_pcwrite", 32'(PCWrite), 32'd0);
    checkOutput("lw_decode_srcb", 32'(ALUSrcB), 32'd3);
    nextCycle();
    checkOutput("lw_c4_memaddr", 32'(State), 32'd3);
    checkOutput("lw_memaddr_srca", 32'(ALUSrcA), 32'd1);
    checkOutput("lw_memaddr_srcb", 32'(ALUSrcB), 32'd2);
    nextCycle();
    checkOutput("lw_c5_memrd", 32'(State), 32'd4);
    checkOutput("lw_memrd_iord", 32'(IorD), 32'd1);
    checkOutput("lw_memrd_memread", 32'(MemRead), 32'd1);
    checkOutput("lw_memrd_regwrite", 32'(RegWrite), 32'd0);
    nextCycle();
    checkOutput("lw_c6_memwb", 32'(State), 32'd5);
    checkOutput("lw_memwb_regwrite", 32'(RegWrite), 32'd1);
    checkOutput("lw_memwb_memtoreg", 32'(MemtoReg), 32'd1);
    checkOutput("lw_memwb_pcwrite", 32'(PCWrite), 32'd0);
    nextCycle();
    checkOutput("lw_back_fetch", 32'(State), 32'd1);

    // sw with MemReady low for three MEM_WR cycles
    applyStimulus(OPC_SW, 6'b0, 1'b1, 1'b0);
    nextCycle();
    checkOutput("sw_decode", 32'(State), 32'd2);
    nextCycle();
    checkOutput("sw_memaddr", 32'(State), 32'd3);
    applyStimulus(OPC_SW, 6'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      if (i == 3) applyStimulus(OPC_SW, 6'b0, 1'b1, 1'b0);
      checkOutput($sformatf("sw_memwr_state_%0d", i), 32'(State), 32'd6);
      checkOutput($sformatf("sw_memwrite_%0d", i), 32'(MemWrite), 32'd1);
      checkOutput($sformatf("sw_iord_%0d", i), 32'(IorD), 32'd1);
    end
    nextCycle();
    checkOutput("sw_back_fetch", 32'(State), 32'd1);

    // R-type subtract
    applyStimulus(OPC_RTYPE, 6'b100010, 1'b1, 1'b0);
    nextCycle();
    checkOutput("r_decode", 32'(State), 32'd2);
    nextCycle();
    checkOutput("r_exec", 32'(State), 32'd7);
    checkOutput("r_exec_aluop", 32'(ALUOp), 32'h22);
    checkOutput("r_exec_srca", 32'(ALUSrcA), 32'd1);
    checkOutput("r_exec_srcb", 32'(ALUSrcB), 32'd0);
    nextCycle();
    checkOutput("r_wb", 32'(State), 32'd8);
    checkOutput("r_wb_aluop", 32'(ALUOp), 32'h22);
    checkOutput("r_wb_regdst", 32'(RegDst), 32'd1);
    checkOutput("r_wb_regwrite", 32'(RegWrite), 32'd1);
    checkOutput("r_wb_memtoreg", 32'(MemtoReg), 32'd0);
    nextCycle();
    checkOutput("r_back_fetch", 32'(State), 32'd1);

    // beq taken, then not taken
    for (int k = 0; k < 2; k++) begin
      logic z;
      z = (k == 0);
      applyStimulus(OPC_BEQ, 6'b0, 1'b1, z);
      nextCycle();
      checkOutput($sformatf("beq%0d_decode", k), 32'(State), 32'd2);
      nextCycle();
      checkOutput($sformatf("beq%0d_branch", k), 32'(State), 32'd9);
      checkOutput($sformatf("beq%0d_pcwrite", k), 32'(PCWrite), 32'(z));
      checkOutput($sformatf("beq%0d_pcsrc", k), 32'(PCSrc), 32'd1);
      checkOutput($sformatf("beq%0d_aluop", k), 32'(ALUOp), 32'h22);
      nextCycle();
      checkOutput($sformatf("beq%0d_back_fetch", k), 32'(State), 32'd1);
    end

    // Fetch timeout: 15 consecutive not-ready cycles end in HALT
    applyStimulus(OPC_LW, 6'b0, 1'b0, 1'b0);
    checkOutput("to_fetch_irwrite", 32'(IRWrite), 32'd0);
    repeat (14) nextCycle();
    checkOutput("to_still_fetch", 32'(State), 32'd1);
    checkOutput("to_memread_held", 32'(MemRead), 32'd1);
    nextCycle();
    checkOutput("to_halt_state", 32'(State), 32'd15);
    checkOutput("to_halt_outs", allOut(), 32'd1);
    nextCycle();
    checkOutput("to_halt_sticky", 32'(State), 32'd15);
    checkOutput("to_fault_sticky", 32'(Fault), 32'd1);
    Rst = 1'b0;
    #1;
    checkOutput("to_reset_fault", 32'(Fault), 32'd0);
    checkOutput("to_reset_state", 32'(State), 32'd0);
    nextCycle();
    Rst = 1'b1;

    // Ready arrives in the 15th wait cycle and wins over the timeout
    nextCycle();
    checkOutput("tie_fetch", 32'(State), 32'd1);
    repeat (14) nextCycle();
    applyStimulus(OPC_LW, 6'b0, 1'b1, 1'b0);
    checkOutput("tie_fetch_15", 32'(State), 32'd1);
    nextCycle();
    checkOutput("tie_decode", 32'(State), 32'd2);
    checkOutput("tie_no_fault", 32'(Fault), 32'd0);

    // Jump opcode decoded from DECODE
    applyStimulus(OPC_J, 6'b0, 1'b1, 1'b0);
    nextCycle();
`ifdef MC_CTRL_JUMP_EN
    checkOutput("j_state", 32'(State), 32'd10);
    checkOutput("j_pcsrc", 32'(PCSrc), 32'd2);
    checkOutput("j_pcwrite", 32'(PCWrite), 32'd1);
    checkOutput("j_fault", 32'(Fault), 32'd0);
    nextCycle();
    checkOutput("j_back_fetch", 32'(State), 32'd1);
`else
    checkOutput("j_illegal_state", 32'(State), 32'd15);
    checkOutput("j_illegal_fault", 32'(Fault), 32'd1);
`endif

    // Reset pulsed in the middle of a stalled MEM_RD
    Rst = 1'b0;
    #1;
    nextCycle();
    Rst = 1'b1;
    applyStimulus(OPC_LW, 6'b0, 1'b1, 1'b0);
    nextCycle();
    nextCycle();
    nextCycle();
    checkOutput("rst_mid_memaddr", 32'(State), 32'd3);
    applyStimulus(OPC_LW, 6'b0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("rst_mid_memrd", 32'(State), 32'd4);
    checkOutput("rst_mid_memread", 32'(MemRead), 32'd1);
    nextCycle();
    #3;
    Rst = 1'b0;
    #1;
    checkOutput("rst_mid_state", 32'(State), 32'd0);
    checkOutput("rst_mid_outs", allOut(), 32'd0);
    nextCycle();
    Rst = 1'b1;
    nextCycle();
    checkOutput("rst_mid_refetch", 32'(State), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
